// File: rtl/prog_delay_pkg.sv
// Shared definitions for the programmable delay FIFO.
//
// Contents:
//   delay_state_e  - fill-tracking state (EMPTY, FILLING, PRIMED)
//   DEFAULT_DEPTH  - default ring depth (maximum delay in shifts)
//   DEFAULT_BITS   - default data width
package prog_delay_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PRIMED  = 2'd2
  } delay_state_e;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_BITS  = 64;

endpackage

// File: rtl/prog_delay_fifo.sv
// Programmable-delay FIFO built on a DEPTH-entry ring buffer.
//
// Every cycle with en=1 writes d/d_valid at the write pointer and advances
// it. The output is read delay_r entries behind the write pointer, so a word
// written by shift k appears on q once shift k+delay_r-1 has completed.
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst_n     - asynchronous active-low reset
//   en        - shift enable (one write + pointer advance per cycle)
//   clr       - synchronous flush of ring, pointer and fill count
//   d         - data in (BITS)
//   d_valid   - valid tag stored alongside d
//   cfg_wr    - load delay_cfg into the active delay register
//   delay_cfg - requested delay, legal range 1..DEPTH (PW+1 bits)
//   q         - delayed data (BITS)
//   q_valid   - delayed tag, qualified by primed
//   fill_cnt  - shifts since reset/clr, saturating at DEPTH (PW+1 bits)
//   primed    - fill_cnt >= active delay
//   cfg_err   - one-cycle pulse after an illegal cfg_wr
module prog_delay_fifo
  import prog_delay_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BITS  = DEFAULT_BITS,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [BITS-1:0] d,
  input  logic            d_valid,
  input  logic            cfg_wr,
  input  logic [PW:0]     delay_cfg,
  output logic [BITS-1:0] q,
  output logic            q_valid,
  output logic [PW:0]     fill_cnt,
  output logic            primed,
  output logic            cfg_err
);

  localparam logic [PW:0] MAX_DELAY = (PW+1)'(DEPTH);

  logic [BITS-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_addr;
  logic [PW:0]      delay_r;
  logic [PW:0]      next_fill;
  logic [PW:0]      next_delay;
  logic             cfg_legal;
  logic             shift;
  delay_state_e     state;
  delay_state_e     next_state;

  // clr wins over a coincident en, so the shift is dropped.
  assign shift     = en & ~clr;
  assign cfg_legal = (delay_cfg != '0) && (delay_cfg <= MAX_DELAY);

  // DEPTH is a power of two, so the modulo is plain PW-bit wraparound.
  // A delay of DEPTH has zero low bits and reads the entry about to be
  // overwritten, i.e. the oldest word in the ring.
  assign rd_addr = wr_ptr - delay_r[PW-1:0];

  // Ring storage and write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld    <= '0;
      wr_ptr <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld    <= '0;
      wr_ptr <= '0;
    end else if (en) begin
      mem[wr_ptr] <= d;
      vld[wr_ptr] <= d_valid;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  // Next fill count and delay. The FSM is steered by these next values so
  // that state always agrees with the registered fill_cnt/delay_r pair,
  // which makes primed react in the same cycle a new delay takes effect.
  always_comb begin
    next_fill  = fill_cnt;
    next_delay = delay_r;
    next_state = state;

    if (clr) begin
      next_fill = '0;
    end else if (shift && (fill_cnt != MAX_DELAY)) begin
      next_fill = fill_cnt + 1'b1;
    end

    if (cfg_wr && cfg_legal) begin
      next_delay = delay_cfg;
    end

    if (next_fill == '0) begin
      next_state = EMPTY;
    end else if (next_fill < next_delay) begin
      next_state = FILLING;
    end else begin
      next_state = PRIMED;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Fill counter, active delay and configuration error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      delay_r  <= MAX_DELAY;
      cfg_err  <= 1'b0;
    end else begin
      fill_cnt <= next_fill;
      delay_r  <= next_delay;
      cfg_err  <= cfg_wr & ~cfg_legal;
    end
  end

  assign primed  = (state == PRIMED);
  assign q       = mem[rd_addr];
  assign q_valid = vld[rd_addr] & primed;

endmodule

// File: tb/tb_prog_delay_fifo.sv
// Self-checking bench for prog_delay_fifo (DEPTH=8, BITS=64).
//
// A history-list model records every word shifted in since the last reset
// or clr; the expected output is simply the word written delay shifts ago.
// Directed literal checks pin the model at the interesting points.
module tb_prog_delay_fifo;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;
  localparam int PW    = 3;
  localparam int HMAX  = 256;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            clr;
  logic [BITS-1:0] d;
  logic            d_valid;
  logic            cfg_wr;
  logic [PW:0]     delay_cfg;
  logic [BITS-1:0] q;
  logic            q_valid;
  logic [PW:0]     fill_cnt;
  logic            primed;
  logic            cfg_err;

  int errors;
  int checks;

  // Model state: words shifted in since reset/clr, active delay, error flag.
  logic [BITS-1:0] hist [HMAX];
  logic            hv   [HMAX];
  int              n_shift;
  int              m_delay;
  logic            m_cfg_err;

  prog_delay_fifo #(
    .DEPTH(DEPTH),
    .BITS (BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .d        (d),
    .d_valid  (d_valid),
    .cfg_wr   (cfg_wr),
    .delay_cfg(delay_cfg),
    .q        (q),
    .q_valid  (q_valid),
    .fill_cnt (fill_cnt),
    .primed   (primed),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [BITS-1:0] got,
                           input logic [BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    n_shift   = 0;
    m_delay   = DEPTH;
    m_cfg_err = 1'b0;
  endtask

  // Compare every DUT output against the history model.
  task automatic check_output();
    logic [BITS-1:0] exp_q;
    logic            exp_qv;
    int              exp_fill;
    exp_q  = '0;
    exp_qv = 1'b0;
    if (n_shift >= m_delay) begin
      exp_q  = hist[n_shift - m_delay];
      exp_qv = hv[n_shift - m_delay];
    end
    exp_fill = (n_shift > DEPTH) ? DEPTH : n_shift;
    check_val("q", q, exp_q);
    check_val("q_valid", {63'd0, q_valid}, {63'd0, exp_qv});
    check_val("fill_cnt", {60'd0, fill_cnt}, 64'(exp_fill));
    check_val("primed", {63'd0, primed}, {63'd0, (n_shift >= m_delay)});
    check_val("cfg_err", {63'd0, cfg_err}, {63'd0, m_cfg_err});
  endtask

  // Drive one cycle of inputs (from a negedge), clock it, advance the model
  // and check at the following negedge.
  task automatic apply_stimulus(input logic i_en, input logic i_clr,
                                input logic [BITS-1:0] i_d, input logic i_dv,
                                input logic i_cfg, input int i_cfg_val);
    en        = i_en;
    clr       = i_clr;
    d         = i_d;
    d_valid   = i_dv;
    cfg_wr    = i_cfg;
    delay_cfg = (PW+1)'(i_cfg_val);
    @(posedge clk);
    m_cfg_err = i_cfg && (i_cfg_val == 0 || i_cfg_val > DEPTH);
    if (i_clr) begin
      n_shift = 0;
    end else if (i_en) begin
      if (n_shift < HMAX) begin
        hist[n_shift] = i_d;
        hv[n_shift]   = i_dv;
      end
      n_shift++;
    end
    if (i_cfg && !m_cfg_err) m_delay = i_cfg_val;
    @(negedge clk);
    check_output();
  endtask

  task automatic shift_in(input logic [BITS-1:0] i_d, input logic i_dv);
    apply_stimulus(1'b1, 1'b0, i_d, i_dv, 1'b0, 0);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    d         = '0;
    d_valid   = 1'b0;
    cfg_wr    = 1'b0;
    delay_cfg = '0;
    model_reset();

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_q", q, 64'd0);
    check_val("reset_fill", {60'd0, fill_cnt}, 64'd0);
    check_val("reset_primed", {63'd0, primed}, 64'd0);
    check_val("reset_cfg_err", {63'd0, cfg_err}, 64'd0);
    rst_n = 1'b1;
    idle();

    // Default delay 8, d = 1..10.
    for (int k = 1; k <= 10; k++) begin
      shift_in(64'(k), 1'b1);
      if (k == 7) begin
        check_val("dly8_q_at7", q, 64'd0);
        check_val("dly8_qv_at7", {63'd0, q_valid}, 64'd0);
      end
      if (k == 8) begin
        check_val("dly8_q_at8", q, 64'd1);
        check_val("dly8_qv_at8", {63'd0, q_valid}, 64'd1);
      end
    end
    check_val("dly8_q_at10", q, 64'd3);
    check_val("dly8_fill_sat", {60'd0, fill_cnt}, 64'd8);

    // Illegal delays: 0 and 9 each pulse cfg_err, delay stays 8.
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 0);
    check_val("cfg0_err", {63'd0, cfg_err}, 64'd1);
    idle();
    check_val("cfg0_err_gone", {63'd0, cfg_err}, 64'd0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 9);
    check_val("cfg9_err", {63'd0, cfg_err}, 64'd1);
    idle();
    check_val("cfg9_keep_q", q, 64'd3);
    check_val("cfg9_keep_primed", {63'd0, primed}, 64'd1);

    // clr together with cfg_wr=3, then A..D.
    apply_stimulus(1'b0, 1'b1, '0, 1'b0, 1'b1, 3);
    check_val("clr_fill", {60'd0, fill_cnt}, 64'd0);
    shift_in(64'hA, 1'b1);
    shift_in(64'hB, 1'b1);
    check_val("dly3_unprimed_at2", {63'd0, primed}, 64'd0);
    shift_in(64'hC, 1'b1);
    check_val("dly3_primed_at3", {63'd0, primed}, 64'd1);
    check_val("dly3_q_at3", q, 64'hA);
    shift_in(64'hD, 1'b0);
    check_val("dly3_q_at4", q, 64'hB);

    // Back to delay 8 alongside a shift, then wrap with mixed valid tags.
    apply_stimulus(1'b1, 1'b0, 64'h300, 1'b1, 1'b1, 8);
    for (int k = 1; k <= 12; k++) shift_in(64'h300 + 64'(k), (k % 3) != 0);
    idle();

    // clr beats a coincident en carrying 0x55.
    apply_stimulus(1'b1, 1'b1, 64'h55, 1'b1, 1'b0, 0);
    check_val("clr_en_fill", {60'd0, fill_cnt}, 64'd0);
    check_val("clr_en_q", q, 64'd0);
    check_val("clr_en_qv", {63'd0, q_valid}, 64'd0);
    for (int k = 1; k <= 9; k++) shift_in(64'h400 + 64'(k), 1'b1);

    // Lower the delay to 2 while primed at 8.
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 2);
    check_val("dly2_q", q, 64'h408);
    check_val("dly2_qv", {63'd0, q_valid}, 64'd1);

    // Raising the delay above fill_cnt drops primed.
    apply_stimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 3; k++) shift_in(64'h500 + 64'(k), 1'b1);
    check_val("raise_pre_primed", {63'd0, primed}, 64'd1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 5);
    check_val("raise_primed", {63'd0, primed}, 64'd0);
    check_val("raise_qv", {63'd0, q_valid}, 64'd0);
    shift_in(64'h504, 1'b1);
    shift_in(64'h505, 1'b1);
    check_val("raise_q_at5", q, 64'h501);

    // Asynchronous reset mid-stream, away from any rising edge.
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_q", q, 64'd0);
    check_val("async_qv", {63'd0, q_valid}, 64'd0);
    check_val("async_fill", {60'd0, fill_cnt}, 64'd0);
    check_val("async_primed", {63'd0, primed}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      shift_in(64'h600 + 64'(k), 1'b1);
      if (k == 7) check_val("post_rst_unprimed_at7", {63'd0, primed}, 64'd0);
    end
    check_val("post_rst_primed_at8", {63'd0, primed}, 64'd1);
    check_val("post_rst_q_at8", q, 64'h601);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
